// File: rtl/shared_counter_arbiter_if.sv
// Bundle between the client FSMs (master) and the shared counter arbiter (slave).
// Requests and terminal counts flow in; grant, status and done pulses flow out.
interface shared_counter_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] dur;
    logic [N_REQ-1:0]       grant;
    logic [ID_W-1:0]        gnt_id;
    logic                   busy;
    logic [CNT_W-1:0]       count;
    logic [N_REQ-1:0]       done;

    modport master (
        output req,
        output dur,
        input  grant,
        input  gnt_id,
        input  busy,
        input  count,
        input  done
    );

    modport slave (
        input  req,
        input  dur,
        output grant,
        output gnt_id,
        output busy,
        output count,
        output done
    );
endinterface

// File: rtl/shared_counter_arbiter.sv
// Round-robin owner selection for a single shared up-counter: the winner's counter
// runs 0..tgt, a one-cycle done pulse follows, then the next arbitration happens.
module shared_counter_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    shared_counter_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [N_REQ-1:0]   r_grant, w_grant_next;
    logic [N_REQ-1:0]   r_done, w_done_next;
    logic [ID_W-1:0]    r_gnt_id, w_gnt_id_next;
    logic [ID_W-1:0]    r_ptr, w_ptr_next;
    logic [CNT_W-1:0]   r_count, w_count_next;
    logic [CNT_W-1:0]   r_tgt, w_tgt_next;

    logic [CNT_W-1:0]   w_dur [N_REQ];
    logic [N_REQ-1:0]   w_win_onehot;
    logic [2*N_REQ-1:0] w_req_dbl;
    logic [N_REQ-1:0]   w_req_rot;
    logic [ID_W:0]      w_rot_amt;
    logic [ID_W:0]      w_off;
    logic [ID_W:0]      w_sum;
    logic [ID_W:0]      w_wrap;
    logic [ID_W-1:0]    w_win_id;
    logic               w_win_found;
    logic               w_owner_req;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_dur[gi]        = bus.dur[gi*CNT_W +: CNT_W];
            assign w_win_onehot[gi] = (w_win_id == ID_W'(gi));
        end
    endgenerate

    // Rotate requests so bit 0 is the requester right after the last owner;
    // the lowest set bit of the rotated vector is then the round-robin winner.
    assign w_rot_amt   = {1'b0, r_ptr} + {{ID_W{1'b0}}, 1'b1};
    assign w_req_dbl   = {bus.req, bus.req} >> w_rot_amt;
    assign w_req_rot   = w_req_dbl[N_REQ-1:0];
    assign w_win_found = |bus.req;

    always_comb begin
        w_off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_req_rot[j]) begin
                w_off = (ID_W+1)'(j);
            end
        end
    end

    assign w_sum    = w_rot_amt + w_off;
    assign w_wrap   = w_sum - (ID_W+1)'(N_REQ);
    assign w_win_id = (w_sum >= (ID_W+1)'(N_REQ)) ? w_wrap[ID_W-1:0] : w_sum[ID_W-1:0];

    assign w_owner_req = |(bus.req & r_grant);

    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_done_next   = '0;
        w_gnt_id_next = r_gnt_id;
        w_ptr_next    = r_ptr;
        w_count_next  = r_count;
        w_tgt_next    = r_tgt;

        case (r_state)
            ST_RUN: begin
                if (!w_owner_req) begin
                    w_state_next = ST_IDLE;
                    w_grant_next = '0;
                    w_count_next = '0;
                end else if (r_count == r_tgt) begin
                    w_state_next = ST_DONE;
                    w_done_next  = r_grant;
                    w_grant_next = '0;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both arbitrate; the DONE cycle doubles as the gap
                // between back-to-back grants.
                if (w_win_found) begin
                    w_state_next  = ST_RUN;
                    w_grant_next  = w_win_onehot;
                    w_gnt_id_next = w_win_id;
                    w_ptr_next    = w_win_id;
                    w_tgt_next    = w_dur[w_win_id];
                    w_count_next  = '0;
                end else begin
                    w_state_next = ST_IDLE;
                    w_grant_next = '0;
                    w_count_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_done   <= '0;
            r_gnt_id <= '0;
            r_ptr    <= ID_W'(N_REQ - 1);
            r_count  <= '0;
            r_tgt    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_done   <= w_done_next;
            r_gnt_id <= w_gnt_id_next;
            r_ptr    <= w_ptr_next;
            r_count  <= w_count_next;
            r_tgt    <= w_tgt_next;
        end
    end

    assign bus.grant  = r_grant;
    assign bus.done   = r_done;
    assign bus.gnt_id = r_gnt_id;
    assign bus.count  = r_count;
    assign bus.busy   = (r_state == ST_RUN);
endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Bench for shared_counter_arbiter: directed scenarios plus a randomized run
// checked against a job-level model (owner, elapsed cycles, round-robin pointer).
module tb_shared_counter_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    shared_counter_arbiter_if #(.N_REQ(N), .CNT_W(W)) bus();

    shared_counter_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: m_owner=-1 when nobody holds the counter; m_done=-1 when no pulse.
    int m_owner, m_elapsed, m_tgt, m_ptr, m_last, m_done;
    bit m_verbose = 1'b0;

    function automatic logic [N-1:0] onehot(input int id);
        logic [N-1:0] v;
        v = '0;
        if (id >= 0) v = N'(1 << id);
        return v;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_elapsed = 0; m_tgt = 0;
        m_ptr = N - 1; m_last = 0; m_done = -1;
    endtask

    task automatic model_step();
        m_done = -1;
        if (m_owner >= 0) begin
            if (((bus.req >> m_owner) & N'(1)) == '0) begin
                m_owner = -1;
            end else if (m_elapsed == m_tgt) begin
                m_done = m_owner;
                m_owner = -1;
            end else begin
                m_elapsed++;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (((bus.req >> i) & N'(1)) != '0) begin
                    m_owner = i; m_ptr = i; m_last = i; m_elapsed = 0;
                    m_tgt = int'(W'(bus.dur >> (i * W)));
                    if (m_verbose) $display("txn: grant id=%0d tgt=%0d t=%0t", i, m_tgt, $time);
                    break;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic do_reset();
        #2;
        bus.req = '0;
        bus.dur = '0;
        reset_n = 1'b0;
        model_reset();
        #3;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.dur = '0; reset_n = 1'b0; model_reset();
        #12;
        total++; if (bus.grant !== 4'b0) begin bad++; $display("FAIL rst_grant got=%b want=0000", bus.grant); end
        total++; if (bus.done !== 4'b0) begin bad++; $display("FAIL rst_done got=%b want=0000", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        total++; if (bus.count !== 8'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.count); end
        total++; if (bus.gnt_id !== 2'd0) begin bad++; $display("FAIL rst_gnt_id got=%0d want=0", bus.gnt_id); end
        reset_n = 1'b1;
        bus.req = 4'b0001;
        bus.dur[0 +: W] = 8'd20;
        repeat (6) cycle();
        total++; if (bus.count !== 8'd5) begin bad++; $display("FAIL rst_pre_count got=%0d want=5", bus.count); end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++; if (bus.grant !== 4'b0) begin bad++; $display("FAIL rst_async_grant got=%b want=0000", bus.grant); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b want=0", bus.busy); end
        total++; if (bus.count !== 8'd0) begin bad++; $display("FAIL rst_async_count got=%0d want=0", bus.count); end
        total++; if (bus.done !== 4'b0) begin bad++; $display("FAIL rst_async_done got=%b want=0000", bus.done); end
        bus.req = 4'b1001;
        #2;
        reset_n = 1'b1;
        cycle();
        total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL rst_first_winner got=%b want=0001", bus.grant); end
        $display("txn: reset test complete");
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0001;
        bus.dur[0 +: W] = 8'd3;
        cycle();
        for (int t = 0; t <= 3; t++) begin
            total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL single_grant t=%0d got=%b want=0001", t, bus.grant); end
            total++; if (bus.count !== 8'(t)) begin bad++; $display("FAIL single_count got=%0d want=%0d", bus.count, t); end
            total++; if (bus.done !== 4'b0) begin bad++; $display("FAIL single_done_early t=%0d got=%b want=0000", t, bus.done); end
            cycle();
        end
        total++; if (bus.done !== 4'b0001) begin bad++; $display("FAIL single_done got=%b want=0001", bus.done); end
        total++; if (bus.grant !== 4'b0) begin bad++; $display("FAIL single_grant_off got=%b want=0000", bus.grant); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", bus.busy); end
        bus.req = 4'b0;
        cycle();
        total++; if (bus.done !== 4'b0) begin bad++; $display("FAIL single_done_pulse got=%b want=0000", bus.done); end
        $display("txn: single job dur=3 complete");
    endtask

    task automatic test_round_robin();
        int seq [5] = '{0, 1, 2, 3, 0};
        do_reset();
        bus.req = 4'b1111;
        cycle();
        for (int s = 0; s < 5; s++) begin
            total++; if (bus.grant !== onehot(seq[s])) begin bad++; $display("FAIL rr_grant s=%0d got=%b want=%b", s, bus.grant, onehot(seq[s])); end
            total++; if (bus.gnt_id !== 2'(seq[s])) begin bad++; $display("FAIL rr_gnt_id s=%0d got=%0d want=%0d", s, bus.gnt_id, seq[s]); end
            cycle();
            total++; if (bus.done !== onehot(seq[s])) begin bad++; $display("FAIL rr_done s=%0d got=%b want=%b", s, bus.done, onehot(seq[s])); end
            total++; if (bus.grant !== 4'b0) begin bad++; $display("FAIL rr_gap s=%0d got=%b want=0000", s, bus.grant); end
            cycle();
        end
        bus.req = 4'b0;
        $display("txn: round robin with dur=0 complete");
    endtask

    task automatic test_abort();
        do_reset();
        bus.req = 4'b0010;
        bus.dur[1*W +: W] = 8'd10;
        repeat (5) cycle();
        total++; if (bus.count !== 8'd4) begin bad++; $display("FAIL abort_pre_count got=%0d want=4", bus.count); end
        bus.req = 4'b0;
        cycle();
        total++; if (bus.grant !== 4'b0) begin bad++; $display("FAIL abort_grant got=%b want=0000", bus.grant); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
        total++; if (bus.count !== 8'd0) begin bad++; $display("FAIL abort_count got=%0d want=0", bus.count); end
        total++; if (bus.done !== 4'b0) begin bad++; $display("FAIL abort_done got=%b want=0000", bus.done); end
        cycle();
        total++; if (bus.done !== 4'b0) begin bad++; $display("FAIL abort_done_late got=%b want=0000", bus.done); end
        $display("txn: abort at count=4 complete");
    endtask

    task automatic test_max_dur();
        do_reset();
        bus.req = 4'b0001;
        bus.dur[0 +: W] = 8'd255;
        cycle();
        for (int c = 1; c <= 256; c++) begin
            total++; if (bus.count !== 8'(c - 1)) begin bad++; $display("FAIL maxdur_count cyc=%0d got=%0d want=%0d", c, bus.count, c - 1); end
            total++; if (bus.done !== 4'b0) begin bad++; $display("FAIL maxdur_done_early cyc=%0d got=%b", c, bus.done); end
            cycle();
        end
        total++; if (bus.done !== 4'b0001) begin bad++; $display("FAIL maxdur_done cyc=257 got=%b want=0001", bus.done); end
        total++; if (bus.count !== 8'd0) begin bad++; $display("FAIL maxdur_count_end got=%0d want=0", bus.count); end
        bus.req = 4'b0;
        $display("txn: dur=255 job complete");
    endtask

    task automatic test_late_req();
        do_reset();
        bus.req = 4'b0001;
        bus.dur[0 +: W] = 8'd2;
        bus.dur[2*W +: W] = 8'd1;
        repeat (2) cycle();
        total++; if (bus.count !== 8'd1) begin bad++; $display("FAIL late_pre_count got=%0d want=1", bus.count); end
        bus.req = 4'b0101;
        cycle();
        total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL late_hold got=%b want=0001", bus.grant); end
        cycle();
        total++; if (bus.done !== 4'b0001) begin bad++; $display("FAIL late_done got=%b want=0001", bus.done); end
        cycle();
        total++; if (bus.grant !== 4'b0100) begin bad++; $display("FAIL late_grant got=%b want=0100", bus.grant); end
        total++; if (bus.gnt_id !== 2'd2) begin bad++; $display("FAIL late_gnt_id got=%0d want=2", bus.gnt_id); end
        bus.req = 4'b0;
        $display("txn: late request served after done");
    endtask

    task automatic test_random();
        do_reset();
        m_verbose = 1'b1;
        for (int it = 0; it < 2000; it++) begin
            bus.req = bus.req ^ (N'($urandom) & N'($urandom) & N'($urandom));
            if ($urandom_range(3) == 0) bus.dur = (N*W)'($urandom) & {N{8'h07}};
            if ($urandom_range(499) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #3;
                reset_n = 1'b1;
            end
            cycle();
            total++; if (bus.grant !== onehot(m_owner)) begin bad++; $display("FAIL rnd_grant it=%0d got=%b want=%b", it, bus.grant, onehot(m_owner)); end
            total++; if (bus.done !== onehot(m_done)) begin bad++; $display("FAIL rnd_done it=%0d got=%b want=%b", it, bus.done, onehot(m_done)); end
            total++; if (bus.busy !== (m_owner >= 0)) begin bad++; $display("FAIL rnd_busy it=%0d got=%b want=%b", it, bus.busy, m_owner >= 0); end
            total++; if (bus.count !== ((m_owner >= 0) ? 8'(m_elapsed) : 8'd0)) begin bad++; $display("FAIL rnd_count it=%0d got=%0d want=%0d", it, bus.count, (m_owner >= 0) ? m_elapsed : 0); end
            total++; if (bus.gnt_id !== 2'(m_last)) begin bad++; $display("FAIL rnd_gnt_id it=%0d got=%0d want=%0d", it, bus.gnt_id, m_last); end
        end
        m_verbose = 1'b0;
        bus.req = 4'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_max_dur();
        test_late_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
